// File: rtl/ring_push_pack.sv
// Packs sparse write lanes into low lanes and feeds the ring buffer
// through a 2-entry skid queue. Optional counters: RING_PUSH_PACK_STAT_EN.
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif
`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Enable_
`define Enable_ 1'b0
`endif

module ring_push_pack #(
    parameter int DATA = 32,
    parameter int LANE = 4,
    parameter bit ACT  = `High
) (
    input  logic                       clk,
    input  logic                       reset_,
    input  logic                       flush_,
    input  logic [LANE-1:0]            in_v,
    input  logic [LANE-1:0][DATA-1:0]  in_d,
    output logic                       in_ready,
    output logic [LANE-1:0]            we,
    output logic [LANE-1:0][DATA-1:0]  wd,
`ifdef RING_PUSH_PACK_STAT_EN
    output logic [31:0]                push_cnt,
    output logic [31:0]                stall_cnt,
`endif
    input  logic                       busy
);

    localparam logic EN  = ACT ? `Enable : `Enable_;
    localparam logic DIS = ~EN;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t                     state;
    logic [LANE-1:0]            t_we;
    logic [LANE-1:0][DATA-1:0]  t_d;

    logic [LANE-1:0]            act;
    logic [LANE-1:0]            pk_we;
    logic [LANE-1:0][DATA-1:0]  pk_d;
    logic                       take;
    logic                       drain;

    always_comb begin
        int pos;
        pos   = 0;
        act   = '0;
        pk_we = {LANE{DIS}};
        pk_d  = '0;
        for (int i = 0; i < LANE; i++) act[i] = (in_v[i] == EN);
        // Each enabled source lane lands at the count of enabled lanes below it
        for (int i = 0; i < LANE; i++) begin
            if (act[i]) begin
                for (int j = 0; j < LANE; j++) begin
                    if (j == pos) begin
                        pk_we[j] = EN;
                        pk_d[j]  = in_d[i];
                    end
                end
                pos = pos + 1;
            end
        end
    end

    assign take  = in_ready && (|act);
    assign drain = (state != EMPTY) && !busy;

    // H lives directly in the we/wd output registers
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            we       <= {LANE{DIS}};
            wd       <= '0;
            t_we     <= {LANE{DIS}};
            t_d      <= '0;
        end else if (!flush_) begin
            state    <= EMPTY;
            in_ready <= 1'b1;
            we       <= {LANE{DIS}};
            wd       <= '0;
            t_we     <= {LANE{DIS}};
            t_d      <= '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (take) begin
                        we    <= pk_we;
                        wd    <= pk_d;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (take && drain) begin
                        we <= pk_we;
                        wd <= pk_d;
                    end else if (take) begin
                        t_we     <= pk_we;
                        t_d      <= pk_d;
                        state    <= FULL;
                        in_ready <= 1'b0;
                    end else if (drain) begin
                        we    <= {LANE{DIS}};
                        wd    <= '0;
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        we       <= t_we;
                        wd       <= t_d;
                        t_we     <= {LANE{DIS}};
                        t_d      <= '0;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef RING_PUSH_PACK_STAT_EN
    logic [31:0] lanes;

    always_comb begin
        lanes = '0;
        for (int i = 0; i < LANE; i++) begin
            if (we[i] == EN) lanes = lanes + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            push_cnt  <= '0;
            stall_cnt <= '0;
        end else if (!flush_) begin
            push_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (drain) push_cnt <= push_cnt + lanes;
            if (state != EMPTY && busy && stall_cnt != 32'hffffffff)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ring_push_pack.sv
// Directed bench for ring_push_pack: active-high instance plus an
// active-low instance for polarity.
module tb_ring_push_pack;

    logic                clk = 1'b0;
    logic                reset_;
    logic                flush_;
    logic [3:0]          in_v;
    logic [3:0]          in_v_b;
    logic [3:0][31:0]    in_d;
    logic                busy;
    logic                in_ready, in_ready_b;
    logic [3:0]          we, we_b;
    logic [3:0][31:0]    wd, wd_b;
`ifdef RING_PUSH_PACK_STAT_EN
    logic [31:0]         pc, sc, pc_b, sc_b;
`endif

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    ring_push_pack #(.DATA(32), .LANE(4), .ACT(1'b1)) dut (
        .clk      (clk),
        .reset_   (reset_),
        .flush_   (flush_),
        .in_v     (in_v),
        .in_d     (in_d),
        .in_ready (in_ready),
        .we       (we),
        .wd       (wd),
`ifdef RING_PUSH_PACK_STAT_EN
        .push_cnt (pc),
        .stall_cnt(sc),
`endif
        .busy     (busy)
    );

    ring_push_pack #(.DATA(32), .LANE(4), .ACT(1'b0)) dut_b (
        .clk      (clk),
        .reset_   (reset_),
        .flush_   (flush_),
        .in_v     (in_v_b),
        .in_d     (in_d),
        .in_ready (in_ready_b),
        .we       (we_b),
        .wd       (wd_b),
`ifdef RING_PUSH_PACK_STAT_EN
        .push_cnt (pc_b),
        .stall_cnt(sc_b),
`endif
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_ = 1'b0;
        flush_ = 1'b1;
        busy   = 1'b0;
        in_v   = 4'b1111;
        in_v_b = 4'b0000;
        in_d   = {32'h4, 32'h3, 32'h2, 32'h1};
        #2;
        step();
        step();
        chk("rst_ready", 128'(in_ready), 128'h1);
        chk("rst_we",    128'(we),       128'h0);
        chk("rst_wd",    128'(wd),       128'h0);
        chk("rst_we_b",  128'(we_b),     128'hf);
        in_v   = 4'b0000;
        in_v_b = 4'b1111;
        reset_ = 1'b1;
        step();
        chk("post_rst_we", 128'(we), 128'h0);

        // sparse packing
        in_v = 4'b1010;
        in_d = {32'h33, 32'hdead, 32'h11, 32'hbeef};
        step();
        chk("pack_we", 128'(we), 128'h3);
        chk("pack_wd", 128'(wd), {32'h0, 32'h0, 32'h33, 32'h11});
        in_v = 4'b0000;
        step();
        chk("pack_idle", 128'(we), 128'h0);

        // back-pressure fill
        busy = 1'b1;
        in_v = 4'b0001;
        in_d = {32'h0, 32'h0, 32'h0, 32'ha};
        step();
        chk("bp_one_we",    128'(we),       128'h1);
        chk("bp_one_ready", 128'(in_ready), 128'h1);
        in_v = 4'b0011;
        in_d = {32'h0, 32'h0, 32'hc, 32'hb};
        step();
        chk("bp_full_ready", 128'(in_ready), 128'h0);
        chk("bp_full_we",    128'(we),       128'h1);
        chk("bp_full_wd",    128'(wd),       {32'h0, 32'h0, 32'h0, 32'ha});
        in_v = 4'b0000;
        step();
        chk("bp_hold_we", 128'(we), 128'h1);
        chk("bp_hold_wd", 128'(wd), {32'h0, 32'h0, 32'h0, 32'ha});
        busy = 1'b0;
        step();
        chk("bp_t_we",    128'(we),       128'h3);
        chk("bp_t_wd",    128'(wd),       {32'h0, 32'h0, 32'hc, 32'hb});
        chk("bp_t_ready", 128'(in_ready), 128'h1);
        step();
        chk("bp_empty", 128'(we), 128'h0);

        // continuous streaming
        in_v = 4'b1111;
        in_d = {32'h4, 32'h3, 32'h2, 32'h1};
        step();
        chk("st0_we",    128'(we),       128'hf);
        chk("st0_wd",    128'(wd),       {32'h4, 32'h3, 32'h2, 32'h1});
        chk("st0_ready", 128'(in_ready), 128'h1);
        in_d = {32'h8, 32'h7, 32'h6, 32'h5};
        step();
        chk("st1_wd",    128'(wd),       {32'h8, 32'h7, 32'h6, 32'h5});
        chk("st1_ready", 128'(in_ready), 128'h1);
        in_v = 4'b0000;
        step();
        chk("st_idle", 128'(we), 128'h0);

        // flush mid-stall
        busy = 1'b1;
        in_v = 4'b0001;
        in_d = {32'h0, 32'h0, 32'h0, 32'haa};
        step();
        in_d = {32'h0, 32'h0, 32'h0, 32'hbb};
        step();
        chk("fl_full", 128'(in_ready), 128'h0);
        flush_ = 1'b0;
        in_v   = 4'b1111;
        in_d   = {32'hcc, 32'hcc, 32'hcc, 32'hcc};
        step();
        chk("fl_we",    128'(we),       128'h0);
        chk("fl_ready", 128'(in_ready), 128'h1);
        flush_ = 1'b1;
        busy   = 1'b0;
        in_v   = 4'b0000;
        step();
        chk("fl_after1", 128'(we), 128'h0);
        step();
        chk("fl_after2", 128'(we), 128'h0);

        // flush discards an input offered while ready
        flush_ = 1'b0;
        in_v   = 4'b0100;
        step();
        flush_ = 1'b1;
        in_v   = 4'b0000;
        step();
        chk("fl_discard", 128'(we), 128'h0);

        // polarity on the active-low instance
        chk("pol_idle0", 128'(we_b), 128'hf);
        in_v_b = 4'b1110;
        in_d   = {32'h5, 32'h6, 32'h7, 32'hcccccccc};
        step();
        chk("pol_we", 128'(we_b), 128'he);
        chk("pol_wd", 128'(wd_b), {32'h0, 32'h0, 32'h0, 32'hcccccccc});
        in_v_b = 4'b1111;
        step();
        chk("pol_idle1", 128'(we_b), 128'hf);
        chk("pol_wd0",   128'(wd_b), 128'h0);

        // asynchronous reset mid-operation
        busy = 1'b1;
        in_v = 4'b0010;
        in_d = {32'h0, 32'h0, 32'h77, 32'h0};
        step();
        chk("ar_loaded", 128'(we), 128'h1);
        in_v = 4'b0000;
        #2;
        reset_ = 1'b0;
        #1;
        chk("ar_we",    128'(we),       128'h0);
        chk("ar_wd",    128'(wd),       128'h0);
        chk("ar_ready", 128'(in_ready), 128'h1);
        #2;
        reset_ = 1'b1;
        busy   = 1'b0;
        step();
        chk("ar_after", 128'(we), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/ring_push_pack.md
Name: ring_push_pack

Overview:
- Upstream feeder stage for the multi-port ring buffer.
- Accepts up to LANE sparse write requests per cycle, compacts the valid lanes into contiguous low lanes (lane 0 first), and drives the buffer's we/wd write ports.
- Honours the buffer's busy back-pressure through a 2-entry skid queue, so in_ready is a registered signal with no combinational path from busy.

Parameters:
- DATA, 32, data width per lane
- LANE, 4, number of write lanes; equals the ring buffer WRITE parameter
- ACT, `High, active level of in_v and we; the enable value is ACT ? `Enable : `Enable_

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- flush_  in  1  synchronous active-low flush
- in_v  in  LANE  per-lane request valid, polarity set by ACT
- in_d  in  LANE x DATA  per-lane request data, packed [LANE-1:0][DATA-1:0]
- in_ready  out  1  active high; a request is taken this cycle when set
- we  out  LANE  write enables to the ring buffer, polarity set by ACT, contiguous from lane 0
- wd  out  LANE x DATA  write data to the ring buffer
- busy  in  1  active high; the ring buffer refuses writes this cycle

Behaviour:
- Take event: in_ready is set and at least one in_v lane is enabled. An all-disabled in_v is never enqueued.
- Compaction: for k enabled lanes, their data fill entry lanes 0..k-1 in ascending source-lane order. Entry lanes k..LANE-1 hold we disabled and wd 0.
- Queue: 2 entries (head H, tail T) plus a state machine.
  - States: EMPTY, ONE (H valid), FULL (H and T valid).
  - we/wd are driven from H when H is valid. Otherwise we is all disabled and wd is 0.
- Drain event: H is valid and busy is 0. It happens in the same cycle the write lands in the ring buffer.
- State transitions:
  - EMPTY: take -> ONE.
  - ONE: take and drain -> ONE (H replaced by the new entry). Take and no drain -> FULL. Drain only -> EMPTY.
  - FULL: no take is possible. Drain -> ONE (T moves to H). No drain -> FULL, holding H and T unchanged.
- in_ready is registered: it is 1 exactly when the next state is not FULL. in_ready=0 in FULL.
- Latency: an input taken in cycle n appears on we/wd in cycle n+1 when the queue was EMPTY, or when it was ONE and H drained.
- Ordering: strict FIFO. H always drains before T.
- A held entry is stable: while busy=1, we/wd hold unchanged.
- flush_=0 (synchronous):
  - state goes to EMPTY, in_ready=1, we disabled on the next edge.
  - The input in that cycle is discarded.
  - A drain in the flush cycle still completes, because it is combinational toward the ring buffer.
- Reset (reset_=0, asynchronous): state=EMPTY, in_ready=1, we all disabled, wd=0, entry storage cleared. Reset mid-operation discards both entries immediately.
- busy is sampled only in the drain decision. There is no combinational path from busy to in_ready.

Optional Feature:
- Macro: RING_PUSH_PACK_STAT_EN.
- Defined: adds output ports push_cnt[31:0] and stall_cnt[31:0], both reset to 0 and cleared by flush_.
  - push_cnt adds the number of enabled we lanes on each drain event, modulo 2^32.
  - stall_cnt increments each cycle with H valid and busy=1, saturating at 32'hffffffff.
- Undefined: the ports and counters do not exist. Core behaviour is identical in both builds.

Test Plan:
- Reset:
  - Stimulus: reset_=0 with in_v active, then release.
  - Required: in_ready=1, we disabled, wd=0 throughout reset. No entry is captured.
- Sparse packing:
  - Stimulus: ACT=`High, busy=0; in_v=4'b1010 with in_d lane1=32'h11, lane3=32'h33.
  - Required: next cycle we=4'b0011, wd lane0=32'h11, lane1=32'h33, lanes2-3=0. The cycle after, we=0.
- Back-pressure fill:
  - Stimulus: busy=1; take in_v=4'b0001 d=32'ha, then in_v=4'b0011 d=32'hb,32'hc.
  - Required: state FULL, in_ready=0 and we=4'b0001 wd lane0=32'ha held stable.
  - Stimulus: release busy.
  - Required: 32'ha drains, then we=4'b0011 with 32'hb,32'hc. in_ready returns to 1 one cycle after the first drain.
- Continuous streaming:
  - Stimulus: busy=0; in_v=4'b1111 every cycle with incrementing data 32'h1..32'h8 over 2 cycles.
  - Required: back-to-back writes at one entry per cycle in order. in_ready stays 1.
- Flush mid-stall:
  - Stimulus: FULL state with busy=1, pulse flush_=0 for one cycle.
  - Required: next cycle we disabled, in_ready=1. Neither entry ever appears on we afterward.
- Polarity:
  - Stimulus: ACT=`Low; in_v=4'b1110 (lane0 enabled) d=32'hcccccccc.
  - Required: we=4'b1110 with wd lane0=32'hcccccccc. When idle, we=4'b1111.
